// File: rtl/aud_dac_serializer_pkg.sv
// aud_dac_serializer_pkg: shared audio defaults and codec format constants
// (left-justified data, LRCK high marks the left slot).
package aud_dac_serializer_pkg;

    localparam int   AUD_DATA_WIDTH = 16;
    localparam logic AUD_LRCK_LEFT  = 1'b1;
    localparam int   AUD_MSB_DELAY  = 0;

    typedef enum logic {
        LINK_IDLE,
        LINK_RUN
    } link_state_e;

    function automatic logic aud_lrck(input logic left_slot);
        return left_slot ? AUD_LRCK_LEFT : ~AUD_LRCK_LEFT;
    endfunction

endpackage

// File: rtl/aud_sample_fifo.sv
// aud_sample_fifo: stereo-pair FIFO with show-ahead read data and occupancy level.
module aud_sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             wr, rd;

    assign full     = level == LW'(DEPTH);
    assign empty    = level == '0;
    assign wr       = push & ~full;
    assign rd       = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd) rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(wr) - LW'(rd);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/aud_dac_serializer.sv
// aud_dac_serializer: buffers stereo pairs and streams them to a codec as
// left-justified serial audio with generated BCLK and DACLRCK.
module aud_dac_serializer
    import aud_dac_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = AUD_DATA_WIDTH,
    parameter int BCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic [DATA_WIDTH-1:0]       left_data,
    input  logic [DATA_WIDTH-1:0]       right_data,
    input  logic                        sample_valid,
    output logic                        sample_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        underflow,
    output logic                        AUD_BCLK,
    output logic                        AUD_DACLRCK,
    output logic                        AUD_DACDAT
);

    localparam int FW = 2 * DATA_WIDTH;
    localparam int DW = $clog2(BCLK_DIV);
    localparam int BW = $clog2(FW);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(FW - 1);
    localparam logic [BW-1:0] SLOT_LEN = BW'(DATA_WIDTH);

    link_state_e   state;
    logic [DW-1:0] div_cnt, div_nxt;
    logic [BW-1:0] bit_cnt, bit_nxt;
    logic [FW-1:0] shreg, pop_data, load_word;
    logic          full, empty, push, pop, div_wrap, frame_start;

    assign sample_ready = ~full;
    assign push         = sample_valid & ~full;
    assign div_wrap     = div_cnt == DIV_LAST;
    assign div_nxt      = div_wrap ? '0 : div_cnt + 1'b1;
    assign bit_nxt      = bit_cnt + 1'b1;
    // The first enabled edge after idle starts a frame immediately.
    assign frame_start  = enable && (state == LINK_IDLE || (div_wrap && bit_cnt == BIT_LAST));
    assign pop          = frame_start & ~empty;
    assign load_word    = pop ? pop_data >> AUD_MSB_DELAY : '0;

    aud_sample_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data ({left_data, right_data}),
        .pop       (pop),
        .pop_data  (pop_data),
        .level     (fifo_level),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= LINK_IDLE;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            underflow   <= 1'b0;
            AUD_BCLK    <= 1'b0;
            AUD_DACLRCK <= 1'b0;
            AUD_DACDAT  <= 1'b0;
        end else if (!enable) begin
            state       <= LINK_IDLE;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            underflow   <= 1'b0;
            AUD_BCLK    <= 1'b0;
            AUD_DACLRCK <= 1'b0;
            AUD_DACDAT  <= 1'b0;
        end else begin
            state     <= LINK_RUN;
            underflow <= frame_start & empty;
            if (frame_start) begin
                div_cnt     <= '0;
                bit_cnt     <= '0;
                shreg       <= load_word;
                AUD_BCLK    <= 1'b0;
                AUD_DACLRCK <= aud_lrck(1'b1);
                AUD_DACDAT  <= load_word[FW-1];
            end else begin
                div_cnt  <= div_nxt;
                AUD_BCLK <= div_nxt >= DIV_HALF;
                // Data and LRCK move together on the BCLK falling edge.
                if (div_wrap) begin
                    bit_cnt     <= bit_nxt;
                    shreg       <= shreg << 1;
                    AUD_DACDAT  <= shreg[FW-2];
                    AUD_DACLRCK <= aud_lrck(bit_nxt < SLOT_LEN);
                end
            end
        end
    end

endmodule
